// File: rtl/spi_master_if.sv
// Bus bundle for the SPI mode-0 initiator: host request/response signals plus serial pins.
// The master modport is the initiator's view; slave is the host/target side.
interface spi_master_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       CS;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, rw, addr, wdata, MISO,
    output rdata, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, rw, addr, wdata, MISO,
    input  rdata, busy, done, SCLK, CS, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Single-transaction SPI mode-0 initiator: sends {addr, rw, byte1} MSB first and, for reads,
// captures the slave's byte1 from MISO.
module spi_master #(
  parameter int unsigned CLKDIV = 8
) (
  input logic          clk,
  input logic          reset,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(CLKDIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  edge_q, edge_d;
  logic [15:0] shreg_q, shreg_d;
  logic [7:0]  rxreg_q, rxreg_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;

  logic       tick;
  logic [5:0] edge_nxt;
  logic       miso_sample;

  assign tick     = (cnt_q == DivLast);
  assign edge_nxt = edge_q + 6'd1;

  // Sample in the first cycle SCLK is high, for byte1 rises (edges 17, 19 .. 31) of a read.
  assign miso_sample = (state_q == StShift) && rw_q && sclk_q && (cnt_q == 8'd0) &&
                       edge_q[0] && (edge_q >= 6'd17);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    shreg_d = shreg_q;
    rxreg_d = rxreg_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    cs_d    = cs_q;

    if (state_q == StIdle) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    if (miso_sample) begin
      rxreg_d = {rxreg_q[6:0], bus.MISO};
    end

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          rw_d    = bus.rw;
          edge_d  = 6'd0;
          rxreg_d = 8'h00;
          // Reads shift out zeros during byte1.
          shreg_d = {bus.addr, bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
        end
      end
      StSetup: begin
        if (tick) begin
          sclk_d  = 1'b1;
          edge_d  = edge_nxt;
          state_d = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          edge_d = edge_nxt;
          if (edge_nxt[0]) begin
            sclk_d = 1'b1;
          end else begin
            // Every fall shifts; the 16th shift empties the register so MOSI returns to 0.
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[14:0], 1'b0};
            if (edge_nxt == 6'd32) begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          cs_d    = 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          edge_d  = 6'd0;
          state_d = StIdle;
          if (rw_q) begin
            rdata_d = rxreg_q;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      edge_q  <= 6'd0;
      shreg_q <= 16'h0000;
      rxreg_q <= 8'h00;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shreg_q <= shreg_d;
      rxreg_q <= rxreg_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.SCLK  = sclk_q;
  assign bus.CS    = cs_q;
  assign bus.MOSI  = shreg_q[15];

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write, read, ignored start while busy, mid-frame reset and
// back-to-back frames, observed through a small mode-0 slave monitor.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int unsigned Div = 8;

  logic clk = 1'b0;
  logic reset;

  spi_master_if intf ();

  spi_master #(.CLKDIV(Div)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (intf.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave-side monitor state
  logic        cs_prev    = 1'b1;
  logic        sclk_prev  = 1'b0;
  logic        miso_q     = 1'b0;
  logic [7:0]  miso_byte  = 8'h00;
  logic [15:0] frame_cap  = 16'h0000;
  logic [15:0] last_frame = 16'h0000;
  logic [2:0]  miso_idx;
  int nbits = 0, sclk_hi = 0, cs_low = 0, done_total = 0;
  int last_nbits = 0, last_hi = 0, last_cslow = 0;

  assign intf.MISO = miso_q;

  always @(negedge clk) begin
    if (cs_prev && !intf.CS) begin
      nbits = 0; frame_cap = 16'h0000; sclk_hi = 0; cs_low = 0;
    end
    if (!intf.CS) cs_low++;
    if (!intf.CS && intf.SCLK) sclk_hi++;
    if (intf.SCLK && !sclk_prev) begin
      frame_cap = {frame_cap[14:0], intf.MOSI};
      nbits++;
    end
    // Mode-0 slave changes MISO on SCLK falls; byte1 occupies rises 9..16.
    if (!intf.SCLK && sclk_prev) begin
      miso_idx = 3'(15 - nbits);
      miso_q   = (nbits >= 8 && nbits <= 15) ? miso_byte[miso_idx] : 1'b0;
    end
    if (intf.CS && !cs_prev) begin
      last_frame = frame_cap; last_nbits = nbits; last_hi = sclk_hi; last_cslow = cs_low;
    end
    if (intf.done === 1'b1) done_total++;
    cs_prev   = intf.CS;
    sclk_prev = intf.SCLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns inside cycle T+1.
  task automatic launch(input logic rw, input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    intf.rw = rw; intf.addr = a; intf.wdata = d; intf.start = 1'b1;
    @(posedge clk);
    #1;
    intf.start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok, output int steps);
    ok = 1'b0;
    steps = 0;
    while (!ok && steps < bound) begin
      if (intf.done === 1'b1) ok = 1'b1;
      else begin cyc(1); steps++; end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int steps, bad, d0;

    reset = 1'b1;
    intf.start = 1'b0; intf.rw = 1'b0; intf.addr = 7'h00; intf.wdata = 8'h00;
    cyc(3);
    check("rst_cs", intf.CS, 1);
    check("rst_sclk", intf.SCLK, 0);
    check("rst_mosi", intf.MOSI, 0);
    check("rst_busy", intf.busy, 0);
    check("rst_done", intf.done, 0);
    check("rst_rdata", intf.rdata, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    cyc(2);

    // Write 0x05 <- 0xA5
    launch(1'b0, 7'h05, 8'hA5);
    check("wr_cs_t1", intf.CS, 0);
    check("wr_busy_t1", intf.busy, 1);
    check("wr_mosi_t1", intf.MOSI, 0);
    cyc(263);
    check("wr_cs_t264", intf.CS, 0);
    cyc(1);
    check("wr_cs_t265", intf.CS, 1);
    check("wr_busy_t265", intf.busy, 1);
    cyc(7);
    check("wr_done_t272", intf.done, 0);
    cyc(1);
    check("wr_done_t273", intf.done, 1);
    check("wr_busy_t273", intf.busy, 0);
    check("wr_rdata", intf.rdata, 8'h00);
    check("wr_frame", last_frame, 16'h0AA5);
    check("wr_pulses", last_nbits, 16);
    check("wr_sclk_hi", last_hi, 128);
    check("wr_cs_low", last_cslow, 264);
    cyc(1);
    check("wr_done_t274", intf.done, 0);

    // Read 0x12, slave returns 0x3C; wdata must not leak onto MOSI
    miso_byte = 8'h3C;
    launch(1'b1, 7'h12, 8'hFF);
    check("rd_mosi_t1", intf.MOSI, 0);
    cyc(271);
    check("rd_rdata_t272", intf.rdata, 8'h00);
    check("rd_done_t272", intf.done, 0);
    cyc(1);
    check("rd_done_t273", intf.done, 1);
    check("rd_rdata_t273", intf.rdata, 8'h3C);
    check("rd_frame", last_frame, 16'h2500);

    // start pulsed at T+50 while busy is ignored
    cyc(2);
    d0 = done_total;
    bad = 0;
    launch(1'b0, 7'h33, 8'h5A);
    for (int i = 1; i <= 272; i++) begin
      if (intf.busy !== 1'b1) bad++;
      if (i == 50) begin
        intf.start = 1'b1; intf.rw = 1'b1; intf.addr = 7'h7E; intf.wdata = 8'hFF;
      end
      if (i == 51) intf.start = 1'b0;
      cyc(1);
    end
    check("bz_busy_low_cycles", bad, 0);
    check("bz_done_t273", intf.done, 1);
    cyc(7);
    check("bz_done_count", done_total - d0, 1);
    check("bz_idle_after", intf.busy, 0);
    check("bz_frame", last_frame, 16'h665A);
    check("bz_rdata_kept", intf.rdata, 8'h3C);

    // Reset at edge 10 of a write
    launch(1'b0, 7'h46, 8'hC3);
    cyc(79);
    check("rs_sclk_e9", intf.SCLK, 1);
    cyc(1);
    check("rs_sclk_e10", intf.SCLK, 0);
    check("rs_mosi_e10", intf.MOSI, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rs_cs", intf.CS, 1);
    check("rs_sclk", intf.SCLK, 0);
    check("rs_mosi", intf.MOSI, 0);
    check("rs_busy", intf.busy, 0);
    check("rs_done", intf.done, 0);
    check("rs_rdata", intf.rdata, 8'h00);
    cyc(2);
    @(negedge clk);
    reset = 1'b0;
    d0 = done_total;
    cyc(300);
    check("rs_no_done", done_total - d0, 0);

    miso_byte = 8'hFF;
    launch(1'b1, 7'h7F, 8'h00);
    wait_done(400, ok, steps);
    check("rs_rd_finished", ok, 1);
    check("rs_rd_latency", steps, 272);
    check("rs_rd_rdata", intf.rdata, 8'hFF);
    check("rs_rd_frame", last_frame, 16'hFF00);

    // start held high: two back-to-back writes
    cyc(2);
    d0 = done_total;
    @(negedge clk);
    intf.rw = 1'b0; intf.addr = 7'h01; intf.wdata = 8'h11; intf.start = 1'b1;
    @(posedge clk);
    #1;
    intf.addr = 7'h02; intf.wdata = 8'h22;
    check("bb_cs_t1", intf.CS, 0);
    cyc(263);
    check("bb_cs_t264", intf.CS, 0);
    cyc(1);
    check("bb_cs_t265", intf.CS, 1);
    cyc(8);
    check("bb_done1", intf.done, 1);
    check("bb_cs_t273", intf.CS, 1);
    check("bb_frame1", last_frame, 16'h0211);
    cyc(1);
    intf.start = 1'b0;
    check("bb_cs_t274", intf.CS, 0);
    check("bb_busy_t274", intf.busy, 1);
    wait_done(400, ok, steps);
    check("bb_finished", ok, 1);
    check("bb_latency2", steps, 272);
    check("bb_frame2", last_frame, 16'h0422);
    cyc(2);
    check("bb_done_count", done_total - d0, 2);
    check("bb_idle", intf.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-transaction SPI initiator (mode 0, MSB first) that drives the 16-bit address/data frame the SmolBoi slave decodes.
- Used in system benches and host-side FPGA logic to write or read one byte of slave memory per transaction.
- Generates SCLK, CS and MOSI from the system clock and samples MISO. SCLK is slow enough for the slave's input conditioners to resolve each edge.

Parameters:
- CLKDIV, 8: SCLK half-period in clk cycles. Legal range is 2..255. Values of 4 or more are required when talking to SmolBoi, because of its conditioner latency.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a transaction; sampled only when busy=0
- rw  input  1  1=read, 0=write; latched on accepted start
- addr  input  7  slave byte address; latched on accepted start
- wdata  input  8  write data; latched on accepted start
- rdata  output  8  last read byte; updated only at the done of a read
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at transaction end
- SCLK  output  1  serial clock, idle low
- CS  output  1  chip select, active low, idle high
- MOSI  output  1  master out
- MISO  input  1  slave out, sampled on SCLK rising edges

Behaviour:
- Reset values (asynchronous): CS=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=0, state=IDLE. All counters and the shift register clear.
- Frame: {addr[6:0], rw, byte1}, sent MSB first.
  - Write: byte1 = wdata.
  - Read: MOSI is held 0 during byte1, and MISO is captured instead.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- Timing is measured from cycle T, the cycle in which start=1 is sampled in IDLE:
  - T+1: enter SETUP. CS=0, busy=1, MOSI=frame[15]. The half-period counter starts at 0.
  - Edge k (k=1..32) occurs at T+1+k*CLKDIV. Odd k = SCLK rise; even k = SCLK fall.
  - SHIFT covers edges 1..32.
  - On each fall k=2..30, MOSI advances to the next frame bit in the same cycle SCLK goes low. On fall 32, MOSI=0.
  - Read only: on rises k=17,19..31, the MISO value present in that cycle shifts into an internal register, MSB first.
  - HOLD: SCLK=0, CS=0 for CLKDIV cycles after edge 32.
  - T+1+33*CLKDIV: CS=1, enter GAP.
  - GAP lasts CLKDIV cycles with CS high. This guarantees the slave sees CS deasserted.
  - T+1+34*CLKDIV: done=1 for one cycle, busy=0, return to IDLE. For a read, rdata loads the internal register in that same cycle.
- With CLKDIV=8: CS low T+1..T+264, CS high from T+265, done at T+273.
- Start handling:
  - start while busy=1 is ignored; latched inputs are unaffected.
  - start in the done cycle is accepted, since busy=0 then.
  - Holding start high gives back-to-back transactions separated by the GAP.
- Changes to rw/addr/wdata after acceptance have no effect on the current frame.
- Write transactions never modify rdata.
- Reset mid-transaction:
  - Outputs immediately return to reset values, and rdata clears.
  - No done pulse is produced.
  - The next start behaves exactly as from power-up.
- Counter: 8-bit half-period counter, wraps to 0 on reaching CLKDIV-1. Edge counter is 6-bit, range 0..32.
- MISO is used only on the listed rising edges. It is ignored in all other states.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> CS=1, SCLK=0, MOSI=0, busy=0, done=0, rdata=0x00 without waiting for a clk edge.
- Write, CLKDIV=8, addr=0x05, rw=0, wdata=0xA5 -> MOSI at the 16 rising edges = 0000101 0 10100101. 16 SCLK pulses, each 8 cycles high and 8 low. CS low T+1..T+264; done at T+273; rdata unchanged.
- Read, addr=0x12, rw=1, slave model drives 0x3C on MISO during byte1 -> first byte on MOSI = 0x25, MOSI=0 during byte1. rdata=0x3C and done=1 in the same cycle T+273.
- start pulsed at T+50 during a busy transaction with different addr/wdata -> frame bits unchanged, exactly one done, busy stays high throughout.
- reset asserted at edge 10 of a write -> CS rises immediately, no done. A following read of 0x7F with MISO=0xFF completes normally with rdata=0xFF.
- start held high across two writes (0x01/0x11, then 0x02/0x22) -> CS high for exactly CLKDIV cycles between frames. Second CS low begins the cycle after the first done, and frames are correct.
